// File: rtl/decoder_pkg.sv
// decoder_pkg: shared RV32I opcodes, funct7 values, ALU codes and funct3-to-ALU mapping.
package decoder_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_LINK  = 4'b1011;

    typedef enum logic [1:0] {MODE_OP, MODE_IMM, MODE_BRANCH} dec_mode_e;

    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: funct3/funct7 to ALU code plus legality, shared by OP, OP-IMM and BRANCH.
module alu_op_decode
    import decoder_pkg::*;
(
    input  dec_mode_e   mode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [3:0]  alu_op,
    output logic        legal
);
    always_comb begin
        alu_op = f3_alu(funct3);
        legal  = 1'b1;
        case (mode)
            MODE_OP: begin
                if (funct7 == F7_ALT && funct3 == 3'b000) alu_op = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101) alu_op = ALU_SRA;
                else legal = funct7 == F7_ZERO;
            end
            MODE_IMM: begin
                // funct7 is immediate bits except on shifts, where it selects/validates the shift kind
                if (funct3 == 3'b001) legal = funct7 == F7_ZERO;
                else if (funct3 == 3'b101) begin
                    alu_op = funct7 == F7_ALT ? ALU_SRA : ALU_SRL;
                    legal  = funct7 == F7_ZERO || funct7 == F7_ALT;
                end
            end
            default: begin
                alu_op = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                legal  = funct3[2:1] != 2'b01;
            end
        endcase
    end
endmodule

// File: rtl/instruction_decoder.sv
// instruction_decoder: registered RV32I decode to ALU code and control strobes; illegal words become NOP.
// Defining INSTRUCTION_DECODER_ILLEGAL_EN adds the registered illegal output.
module instruction_decoder
    import decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [3:0]  alu_op,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch
`ifdef INSTRUCTION_DECODER_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;
    dec_mode_e  mode;
    logic [3:0] dec_alu_op;
    logic       dec_legal;
    logic       legal;
    logic [3:0] alu_op_d, alu_op_q;
    logic       reg_write_d, reg_write_q;
    logic       mem_read_d, mem_read_q;
    logic       mem_write_d, mem_write_q;
    logic       branch_d, branch_q;
    logic       illegal_d;

    assign opcode        = instruction[6:0];
    assign funct3        = instruction[14:12];
    assign funct7        = instruction[31:25];
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};
    assign mode = opcode == OPC_BRANCH ? MODE_BRANCH : opcode == OPC_OP_IMM ? MODE_IMM : MODE_OP;

    alu_op_decode u_alu_op_decode (
        .mode   (mode),
        .funct3 (funct3),
        .funct7 (funct7),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    always_comb begin
        alu_op_d    = ALU_ADD;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        branch_d    = 1'b0;
        legal       = 1'b1;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                alu_op_d    = dec_alu_op;
                legal       = dec_legal;
                reg_write_d = 1'b1;
            end
            OPC_LOAD: begin
                legal       = funct3 != 3'b011 && funct3[2:1] != 2'b11;
                reg_write_d = 1'b1;
                mem_read_d  = 1'b1;
            end
            OPC_STORE: begin
                legal       = !funct3[2] && funct3[1:0] != 2'b11;
                mem_write_d = 1'b1;
            end
            OPC_BRANCH: begin
                alu_op_d = dec_alu_op;
                legal    = dec_legal;
                branch_d = 1'b1;
            end
            OPC_LUI: begin
                alu_op_d    = ALU_PASSB;
                reg_write_d = 1'b1;
            end
            OPC_AUIPC: reg_write_d = 1'b1;
            OPC_JAL: begin
                alu_op_d    = ALU_LINK;
                reg_write_d = 1'b1;
            end
            OPC_JALR: begin
                alu_op_d    = ALU_LINK;
                reg_write_d = 1'b1;
                legal       = funct3 == 3'b000;
            end
            default: legal = 1'b0;
        endcase
        illegal_d = !legal;
        if (illegal_d) begin
            alu_op_d    = ALU_ADD;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            branch_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_q    <= ALU_ADD;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end else begin
            alu_op_q    <= alu_op_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign reg_write = reg_write_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign branch    = branch_q;

`ifdef INSTRUCTION_DECODER_ILLEGAL_EN
    logic illegal_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_q <= 1'b0;
        else illegal_q <= illegal_d;
    end
    assign illegal = illegal_q;
`endif
endmodule

// File: tb/tb_instruction_decoder.sv
// tb_instruction_decoder: directed and randomized checks of the registered RV32I decoder.
// Exercises the illegal output when INSTRUCTION_DECODER_ILLEGAL_EN is defined.
module tb_instruction_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic [3:0]  alu_op;
    logic        reg_write, mem_read, mem_write, branch;
    logic        ill_obs;
    logic [8:0]  obs;
    int          tests = 0;
    int          fails = 0;

`ifdef INSTRUCTION_DECODER_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
    logic illegal;
    assign ill_obs = illegal;
`else
    localparam bit ILL_EN = 1'b0;
    assign ill_obs = 1'b0;
`endif

    instruction_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch)
`ifdef INSTRUCTION_DECODER_ILLEGAL_EN
        ,
        .illegal     (illegal)
`endif
    );

    always #5 clk = ~clk;
    assign obs = {alu_op, reg_write, mem_read, mem_write, branch, ill_obs};

    function automatic logic [8:0] ev(input logic [3:0] a, input logic rw, mr, mw, br, il);
        return {a, rw, mr, mw, br, il & ILL_EN};
    endfunction

    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        logic [3:0] a;
        case (f3)
            3'd0: a = 4'd0;
            3'd1: a = 4'd2;
            3'd2: a = 4'd3;
            3'd3: a = 4'd4;
            3'd4: a = 4'd5;
            3'd5: a = 4'd6;
            3'd6: a = 4'd8;
            default: a = 4'd9;
        endcase
        return a;
    endfunction

    function automatic logic [8:0] ref_dec(input logic [31:0] w);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [3:0] a;
        logic rw, mr, mw, br, ok;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        a = 4'd0; rw = 0; mr = 0; mw = 0; br = 0; ok = 0;
        case (op)
            7'h33: begin
                ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                a = f7 == 7'h20 ? (f3 == 3'd0 ? 4'd1 : 4'd7) : base_alu(f3);
                rw = 1;
            end
            7'h13: begin
                ok = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                a = (f3 == 3'd5 && f7 == 7'h20) ? 4'd7 : base_alu(f3);
                rw = 1;
            end
            7'h03: begin ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; rw = 1; mr = 1; end
            7'h23: begin ok = f3 < 3'd3; mw = 1; end
            7'h63: begin
                ok = !(f3 inside {3'd2, 3'd3});
                a = f3 < 3'd2 ? 4'd1 : f3 < 3'd6 ? 4'd3 : 4'd4;
                br = 1;
            end
            7'h37: begin ok = 1; a = 4'd10; rw = 1; end
            7'h17: begin ok = 1; rw = 1; end
            7'h6F: begin ok = 1; a = 4'd11; rw = 1; end
            7'h67: begin ok = f3 == 3'd0; a = 4'd11; rw = 1; end
            default: ok = 0;
        endcase
        return ok ? ev(a, rw, mr, mw, br, 1'b0) : ev(4'd0, 0, 0, 0, 0, 1'b1);
    endfunction

    task automatic apply(input logic [31:0] w);
        instruction = w;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        instruction = 32'h002081B3;
        #3;
        tests++;
        if (obs !== 9'h0) begin fails++; $display("FAIL reset_initial got=%h want=%h", obs, 9'h0); end
        @(posedge clk); #1;
        tests++;
        if (obs !== 9'h0) begin fails++; $display("FAIL reset_hold got=%h want=%h", obs, 9'h0); end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (obs !== ev(4'd0, 1, 0, 0, 0, 0)) begin fails++; $display("FAIL reset_release got=%h want=%h", obs, ev(4'd0, 1, 0, 0, 0, 0)); end
        apply(32'h0040A183);
        tests++;
        if (obs !== ev(4'd0, 1, 1, 0, 0, 0)) begin fails++; $display("FAIL pre_async_rst got=%h want=%h", obs, ev(4'd0, 1, 1, 0, 0, 0)); end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (obs !== 9'h0) begin fails++; $display("FAIL async_rst got=%h want=%h", obs, 9'h0); end
        @(posedge clk); #1;
        tests++;
        if (obs !== 9'h0) begin fails++; $display("FAIL async_rst_hold got=%h want=%h", obs, 9'h0); end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (obs !== ev(4'd0, 1, 1, 0, 0, 0)) begin fails++; $display("FAIL async_rst_release got=%h want=%h", obs, ev(4'd0, 1, 1, 0, 0, 0)); end
    endtask

    task automatic test_basic;
        logic [31:0] w [6];
        logic [8:0]  e [6];
        w[0] = 32'h002081B3; e[0] = ev(4'b0000, 1, 0, 0, 0, 0);
        w[1] = 32'h0040A183; e[1] = ev(4'b0000, 1, 1, 0, 0, 0);
        w[2] = 32'h0030A223; e[2] = ev(4'b0000, 0, 0, 1, 0, 0);
        w[3] = 32'h00110063; e[3] = ev(4'b0001, 0, 0, 0, 1, 0);
        w[4] = 32'h000011B7; e[4] = ev(4'b1010, 1, 0, 0, 0, 0);
        w[5] = 32'h001001EF; e[5] = ev(4'b1011, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            apply(w[i]);
            tests++;
            if (obs !== e[i]) begin fails++; $display("FAIL basic[%0d] word=%h got=%h want=%h", i, w[i], obs, e[i]); end
        end
    endtask

    task automatic test_variants;
        logic [31:0] w [17];
        logic [8:0]  e [17];
        w[0]  = 32'h402081B3; e[0]  = ev(4'b0001, 1, 0, 0, 0, 0);
        w[1]  = 32'h4020D1B3; e[1]  = ev(4'b0111, 1, 0, 0, 0, 0);
        w[2]  = 32'h6020D1B3; e[2]  = ev(4'b0000, 0, 0, 0, 0, 1);
        w[3]  = 32'h0000007F; e[3]  = ev(4'b0000, 0, 0, 0, 0, 1);
        w[4]  = 32'h40101093; e[4]  = ev(4'b0000, 0, 0, 0, 0, 1);
        w[5]  = 32'h4010D093; e[5]  = ev(4'b0111, 1, 0, 0, 0, 0);
        w[6]  = 32'h0010D093; e[6]  = ev(4'b0110, 1, 0, 0, 0, 0);
        w[7]  = 32'h00112063; e[7]  = ev(4'b0000, 0, 0, 0, 0, 1);
        w[8]  = 32'h0020E063; e[8]  = ev(4'b0100, 0, 0, 0, 1, 0);
        w[9]  = 32'h000080E7; e[9]  = ev(4'b1011, 1, 0, 0, 0, 0);
        w[10] = 32'h000090E7; e[10] = ev(4'b0000, 0, 0, 0, 0, 1);
        w[11] = 32'h0000B083; e[11] = ev(4'b0000, 0, 0, 0, 0, 1);
        w[12] = 32'h0000B023; e[12] = ev(4'b0000, 0, 0, 0, 0, 1);
        w[13] = 32'h00000097; e[13] = ev(4'b0000, 1, 0, 0, 0, 0);
        w[14] = 32'hFFF08093; e[14] = ev(4'b0000, 1, 0, 0, 0, 0);
        w[15] = 32'h00000031; e[15] = ev(4'b0000, 0, 0, 0, 0, 1);
        w[16] = 32'h00000000; e[16] = ev(4'b0000, 0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) begin
            apply(w[i]);
            tests++;
            if (obs !== e[i]) begin fails++; $display("FAIL variant[%0d] word=%h got=%h want=%h", i, w[i], obs, e[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w [4];
        logic [8:0]  e [4];
        w[0] = 32'h002081B3; e[0] = ev(4'b0000, 1, 0, 0, 0, 0);
        w[1] = 32'h0040A183; e[1] = ev(4'b0000, 1, 1, 0, 0, 0);
        w[2] = 32'h0030A223; e[2] = ev(4'b0000, 0, 0, 1, 0, 0);
        w[3] = 32'h00110063; e[3] = ev(4'b0001, 0, 0, 0, 1, 0);
        apply(32'h0000007F);
        for (int i = 0; i < 4; i++) begin
            instruction = w[i];
            #2;
            tests++;
            if (i > 0 && obs !== e[i-1] || i == 0 && obs !== ev(4'd0, 0, 0, 0, 0, 1)) begin
                fails++; $display("FAIL b2b_latency[%0d] got=%h before edge", i, obs);
            end
            @(posedge clk); #1;
            tests++;
            if (obs !== e[i]) begin fails++; $display("FAIL b2b[%0d] word=%h got=%h want=%h", i, w[i], obs, e[i]); end
        end
    endtask

    task automatic test_sweep;
        logic [6:0]  ops [9];
        logic [31:0] w;
        logic [8:0]  e;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if (i % 4 != 0) w[6:0] = ops[$urandom_range(0, 8)];
            if (i % 2 == 0) w[31:25] = $urandom_range(0, 1) != 0 ? 7'h20 : 7'h00;
            e = ref_dec(w);
            apply(w);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL sweep[%0d] word=%h got=%h want=%h", i, w, obs, e); end
            tests++;
            if (mem_read && mem_write) begin fails++; $display("FAIL sweep_excl[%0d] word=%h mem_read=%b mem_write=%b", i, w, mem_read, mem_write); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_basic;
        test_variants;
        test_back_to_back;
        test_sweep;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Registered RV32I instruction decoder in the core's decode stage. It takes a 32-bit instruction word and produces the ALU operation code plus the register-write, memory-read, memory-write and conditional-branch control strobes consumed by execute and memory stages. All outputs are registered, with one-cycle latency. Unsupported or malformed encodings decode to a safe NOP, with every strobe deasserted.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- instruction  input  32  instruction word; opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25]
- alu_op  output  4  registered ALU operation code
- reg_write  output  1  registered; rd is written
- mem_read  output  1  registered; load access
- mem_write  output  1  registered; store access
- branch  output  1  registered; conditional branch
- illegal  output  1  registered; present only with INSTRUCTION_DECODER_ILLEGAL_EN

## Operation
- ALU codes:
  - ADD=0000, SUB=0001, SLL=0010, SLT=0011, SLTU=0100, XOR=0101
  - SRL=0110, SRA=0111, OR=1000, AND=1001, PASSB=1010, LINK=1011
  - Codes 1100–1111 are unused.
- OP 0110011:
  - funct7=0000000 with funct3 000/001/010/011/100/101/110/111 gives ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7=0100000 with funct3 000 gives SUB; with funct3 101 gives SRA.
  - reg_write=1. Any other funct7/funct3 combination is illegal.
- OP-IMM 0010011:
  - Same funct3 mapping as OP; funct7 is ignored except on shifts.
  - SLLI requires funct7=0000000.
  - SRLI/SRAI require funct7 0000000 or 0100000, respectively.
  - reg_write=1.
- LOAD 0000011: funct3 000/001/010/100/101 legal; ADD, reg_write=1, mem_read=1.
- STORE 0100011: funct3 000/001/010 legal; ADD, mem_write=1.
- BRANCH 1100011:
  - branch=1.
  - BEQ/BNE (000/001) give SUB.
  - BLT/BGE (100/101) give SLT.
  - BLTU/BGEU (110/111) give SLTU.
  - 010/011 are illegal.
- LUI 0110111: PASSB, reg_write=1.
- AUIPC 0010111: ADD, reg_write=1.
- JAL 1101111: LINK, reg_write=1, branch=0.
- JALR 1100111: funct3=000 required; LINK, reg_write=1.
- Anything else is illegal. This includes opcode[1:0]≠11, unlisted opcodes, and 0000000/1111111.
- Illegal encodings register alu_op=0000 with all strobes 0.
- rd=0 does not suppress reg_write; the register file ignores x0 writes.
- mem_read and mem_write are never both 1.

## Timing
- Decode logic is purely combinational from `instruction`; all outputs are captured on rising clk.
- Latency: the output reflects the instruction sampled at the previous edge (1 cycle).
- Throughput is one instruction per cycle. There is no handshake or stall input; the upstream stage holds `instruction` if needed.
- rst asserted, asynchronously and at any time:
  - alu_op=0000, reg_write=0, mem_read=0, mem_write=0, branch=0, illegal=0.
  - These values hold while rst is high.
- First edge after rst deasserts: the current instruction is decoded and registered.
- X or Z on `instruction` is not required to be handled.

## Configuration
- INSTRUCTION_DECODER_ILLEGAL_EN defined:
  - Adds the `illegal` output, registered alongside the other outputs.
  - It is 1 exactly for the encodings classified illegal above, 0 otherwise, and 0 on reset.
- Undefined: the port and its register do not exist; illegal encodings still decode to NOP.

## Structure
- Shared package `decoder_pkg`:
  - opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR)
  - ALU code localparams or enum (ALU_ADD … ALU_LINK)
  - funct7 constants
- One natural sub-module is `alu_op_decode`: combinational funct3/funct7 to alu_op plus a legal flag, shared by OP, OP-IMM and BRANCH.
- The top level does opcode dispatch and output registers.

## Test plan
- Reset: assert rst mid-stream → all outputs 0 immediately, without waiting for a clock edge. Release → next edge decodes.
- Apply the following words; each result appears one cycle later:
  - 0x002081B3 (ADD x3,x1,x2) → alu_op=0000, reg_write=1, others 0.
  - 0x0040A183 (LW x3,4(x1)) → 0000, reg_write=1, mem_read=1.
  - 0x0030A223 (SW) → 0000, mem_write=1, reg_write=0.
  - 0x00110063 (BEQ) → alu_op=0001, branch=1, others 0.
  - 0x000011B7 (LUI) → 1010, reg_write=1.
  - 0x001001EF (JAL) → 1011, reg_write=1, branch=0.
- 0x0000007F (invalid) → alu_op=0000, all strobes 0; illegal=1 when enabled.
- 0x402081B3 (SUB) → 0001. 0x4020D1B3 (SRA) → 0111. 0x6020D1B3 (bad funct7) → NOP/illegal.
- Back-to-back: new instruction every cycle, ADD → LW → SW → BEQ → outputs track exactly one cycle behind, with no bubbles.
- Exhaustive sweep: random 32-bit words checked against a reference model; mem_read&mem_write never both 1.
